// File: rtl/repeated_subtraction_divider_if.sv
// Operand/result bundle for the repeated-subtraction divider.
// The master drives the request (start, A, B); the slave returns the results and status.
interface repeated_subtraction_divider_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, A, B,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, A, B,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );

endinterface

// File: rtl/repeated_subtraction_divider.sv
// Sequential signed divider: subtracts the divisor magnitude from the dividend
// magnitude once per clock, then restores signs.
// The quotient truncates toward zero, and the remainder takes the sign of the dividend.
// The shared datapath enable freezes every register when it is low.
module repeated_subtraction_divider #(
  parameter int WIDTH = 8
) (
  input logic                          clk,
  input logic                          reset,
  input logic                          enable,
  repeated_subtraction_divider_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SUB,
    FIX,
    DONE
  } state_t;

  // Largest positive quotient, widened to the counter width for the overflow compare.
  localparam logic [WIDTH:0]   MAX_POS = {2'b00, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   CNT_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] Q_SAT   = {1'b0, {(WIDTH-1){1'b1}}};

  state_t           state_q;
  logic [WIDTH-1:0] aCap_q;
  logic [WIDTH-1:0] bCap_q;
  logic             signQ_q;
  logic             signR_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   dvs_q;
  logic [WIDTH:0]   cnt_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             busy_q;
  logic             done_q;
  logic             divZero_q;
  logic             overflow_q;

  logic [WIDTH:0]   aExt;
  logic [WIDTH:0]   bExt;
  logic [WIDTH:0]   aMag_d;
  logic [WIDTH:0]   bMag_d;
  logic [WIDTH:0]   remSub_d;
  logic [WIDTH:0]   cntInc_d;
  logic [WIDTH-1:0] cntLow;
  logic [WIDTH-1:0] remLow;
  logic [WIDTH-1:0] quot_d;
  logic [WIDTH-1:0] rem_d;
  logic             ovf_d;
  logic             bZero;

  // Magnitudes, the subtract step and the sign-restored results.
  // Magnitudes are one bit wider than the operands, so that |-2^(WIDTH-1)| is exact.
  always_comb begin
    aExt     = {aCap_q[WIDTH-1], aCap_q};
    bExt     = {bCap_q[WIDTH-1], bCap_q};
    aMag_d   = aExt[WIDTH] ? -aExt : aExt;
    bMag_d   = bExt[WIDTH] ? -bExt : bExt;
    remSub_d = rem_q - dvs_q;
    cntInc_d = cnt_q + CNT_ONE;
    cntLow   = cnt_q[WIDTH-1:0];
    remLow   = rem_q[WIDTH-1:0];
    bZero    = (bCap_q == '0);
    ovf_d    = ~signQ_q & (cnt_q > MAX_POS);
    if (ovf_d) begin
      quot_d = Q_SAT;
    end else if (signQ_q) begin
      quot_d = -cntLow;
    end else begin
      quot_d = cntLow;
    end
    rem_d = signR_q ? -remLow : remLow;
  end

  // Control FSM with registered outputs.
  // Divide-by-zero skips SUB but still passes through FIX,
  // so that its results and the done pulse land on the same edge as every other operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      aCap_q      <= '0;
      bCap_q      <= '0;
      signQ_q     <= 1'b0;
      signR_q     <= 1'b0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      divZero_q   <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (enable) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            aCap_q     <= bus.A;
            bCap_q     <= bus.B;
            signQ_q    <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            signR_q    <= bus.A[WIDTH-1];
            divZero_q  <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end else begin
            state_q <= IDLE;
          end
        end
        LOAD: begin
          rem_q   <= aMag_d;
          dvs_q   <= bMag_d;
          cnt_q   <= '0;
          state_q <= bZero ? FIX : SUB;
        end
        SUB: begin
          if (rem_q >= dvs_q) begin
            rem_q <= remSub_d;
            cnt_q <= cntInc_d;
          end else begin
            state_q <= FIX;
          end
        end
        FIX: begin
          if (bZero) begin
            quotient_q  <= '0;
            remainder_q <= aCap_q;
            divZero_q   <= 1'b1;
          end else begin
            quotient_q  <= quot_d;
            remainder_q <= rem_d;
            overflow_q  <= ovf_d;
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = divZero_q;
  assign bus.overflow    = overflow_q;

endmodule
